filter_inverse: RTL and testbench

Stream decoder that recovers the original 8-bit sample sequence from the full-precision output of the 3-tap smoothing filter, s[n] = x[n-2] + 2*x[n-1] + x[n], where s is not right-shifted.
- Sits at the receive end of the filtered-sample link.
- Inverts the filter exactly by recursion, x[n] = s[n] - 2*x[n-1] - x[n-2].
- Flags any sum that cannot come from a valid 8-bit source.
- Valid/ready handshake on both sides; one registered output stage.

---
 rtl/filter_inverse.sv | 141 ++++++++++++++
 tb/tb_filter_inverse.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/filter_inverse.sv
// Inverse of the 3-tap smoothing filter s[n] = x[n-2] + 2*x[n-1] + x[n]:
// recovers x[n] by recursion and flags sums no 8-bit source could produce.
module filter_inverse #(
    parameter int W  = 8,
    parameter int SW = W + 2,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_sum,
    input  logic          sync,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          err,
    output logic [CW-1:0] err_count
);

    localparam int RW = SW + 2;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [W-1:0]    x1_r, x2_r, x1_s, x2_s;
    logic [W-1:0]    hist_x1_s, hist_x2_s;
    logic            out_valid_r, out_valid_s;
    logic [W-1:0]    out_data_r, out_data_s;
    logic            err_r, err_s;
    logic [CW-1:0]   err_count_r, err_count_s;
    logic signed [RW-1:0] resid_s;
    logic            legal_s, run_eff_s, in_ready_s, accept_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Residue against the history in effect this cycle (zero when sync is asserted)
    always_comb begin
        hist_x1_s = x1_r;
        hist_x2_s = x2_r;
        if (sync) begin
            hist_x1_s = '0;
            hist_x2_s = '0;
        end else begin
            hist_x1_s = x1_r;
            hist_x2_s = x2_r;
        end
        resid_s = $signed(RW'(in_sum)) - $signed(RW'({hist_x1_s, 1'b0}))
                - $signed(RW'(hist_x2_s));
        legal_s = (resid_s[RW-1] == 1'b0) && (resid_s[RW-2:W] == '0);
    end

    // Handshake: sync puts the block back in RUN rules for this very cycle,
    // so a sample arriving with sync never overwrites an untaken output word.
    always_comb begin
        run_eff_s  = (state_r == ST_RUN) || sync;
        in_ready_s = 1'b1;
        if (run_eff_s) begin
            in_ready_s = !out_valid_r || out_ready;
        end else begin
            in_ready_s = 1'b1;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Next-state and datapath update
    always_comb begin
        state_s     = state_r;
        x1_s        = hist_x1_s;
        x2_s        = hist_x2_s;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        err_s       = err_r;
        err_count_s = err_count_r;

        if (out_valid_r && out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end

        if (sync) begin
            err_s   = 1'b0;
            state_s = ST_RUN;
        end else begin
            state_s = state_r;
        end

        if (accept_s && run_eff_s) begin
            if (legal_s) begin
                out_valid_s = 1'b1;
                out_data_s  = resid_s[W-1:0];
                x2_s        = hist_x1_s;
                x1_s        = resid_s[W-1:0];
            end else begin
                err_s       = 1'b1;
                err_count_s = sat_inc(err_count_r);
                state_s     = ST_ERROR;
            end
        end else begin
            out_data_s = out_data_r;
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_RUN;
            x1_r        <= '0;
            x2_r        <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            err_r       <= 1'b0;
            err_count_r <= '0;
        end else begin
            state_r     <= state_s;
            x1_r        <= x1_s;
            x2_r        <= x2_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            err_r       <= err_s;
            err_count_r <= err_count_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign err       = err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_filter_inverse.sv
// Self-checking bench for filter_inverse: directed scenarios plus random
// traffic compared against a transaction-level integer model.
module tb_filter_inverse;

    logic        CLK = 1'b0;
    logic        RST, in_valid, in_ready, sync, out_valid, out_ready, err;
    logic [9:0]  in_sum;
    logic [7:0]  out_data;
    logic [15:0] err_count;

    always #5 CLK = ~CLK;

    filter_inverse dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .sync(sync), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .err(err), .err_count(err_count)
    );

    int checks = 0;
    int errors = 0;

    // Model: recovered history, pending output word, error bookkeeping
    int mx1, mx2, mdata, mcnt;
    bit mvalid, merr, mrun;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx1 = 0; mx2 = 0; mdata = 0; mcnt = 0;
        mvalid = 1'b0; merr = 1'b0; mrun = 1'b1;
    endtask

    task automatic check_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
        check("out_data", {24'd0, out_data}, mdata);
        check("err", {31'd0, err}, {31'd0, merr});
        check("err_count", {16'd0, err_count}, mcnt);
    endtask

    task automatic do_reset();
        RST = 1'b1; in_valid = 1'b1; in_sum = 10'd300; sync = 1'b0; out_ready = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0; in_valid = 1'b0;
        model_reset();
        check_outputs();
    endtask

    // One clock cycle of stimulus; model predicts the handshake and the result
    task automatic step(input bit v, input int s, input bit y, input bit rd, input bit chk);
        bit exp_rdy, acc, nvalid;
        int r;
        in_valid = v; in_sum = s[9:0]; sync = y; out_ready = rd;
        #1;
        exp_rdy = (mrun || y) ? (!mvalid || rd) : 1'b1;
        if (chk) check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        nvalid = mvalid && !rd;
        if (y) begin
            mx1 = 0; mx2 = 0; merr = 1'b0; mrun = 1'b1;
        end
        if (acc && mrun) begin
            r = s - 2 * mx1 - mx2;
            if (r >= 0 && r <= 255) begin
                nvalid = 1'b1; mdata = r; mx2 = mx1; mx1 = r;
            end else begin
                merr = 1'b1; mrun = 1'b0;
                if (mcnt < 65535) mcnt++;
            end
        end
        mvalid = nvalid;
        @(posedge CLK); #1;
        if (chk) check_outputs();
    endtask

    initial begin
        int s, r;
        bit y;
        RST = 1'b0; in_valid = 1'b0; in_sum = 10'd0; sync = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;

        // Reset state, with a sample offered during reset that must be dropped
        do_reset();
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic decode: 4, 16, 32 -> 4, 8, 12
        step(1'b1, 4, 1'b0, 1'b1, 1'b1);
        check("basic_0", {24'd0, out_data}, 32'd4);
        step(1'b1, 16, 1'b0, 1'b1, 1'b1);
        check("basic_1", {24'd0, out_data}, 32'd8);
        step(1'b1, 32, 1'b0, 1'b1, 1'b1);
        check("basic_2", {24'd0, out_data}, 32'd12);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Overflow then a discarded sum in ERROR
        do_reset();
        step(1'b1, 300, 1'b0, 1'b1, 1'b1);
        check("ovf_err", {31'd0, err}, 32'd1);
        step(1'b1, 4, 1'b0, 1'b1, 1'b1);
        check("ovf_count", {16'd0, err_count}, 32'd1);
        check("ovf_novalid", {31'd0, out_valid}, 32'd0);

        // Negative residue keeps the last good word
        do_reset();
        step(1'b1, 4, 1'b0, 1'b0, 1'b1);
        step(1'b1, 5, 1'b0, 1'b1, 1'b1);
        check("neg_hold", {24'd0, out_data}, 32'd4);

        // Sync recovery decodes against zero history
        step(1'b1, 10, 1'b1, 1'b1, 1'b1);
        check("sync_data", {24'd0, out_data}, 32'd10);
        check("sync_count", {16'd0, err_count}, 32'd1);

        // Backpressure: five stalled cycles, then the sequence resumes in order
        do_reset();
        step(1'b1, 4, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 16, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16, 1'b0, 1'b1, 1'b1);
        check("bp_resume_0", {24'd0, out_data}, 32'd8);
        step(1'b1, 32, 1'b0, 1'b1, 1'b1);
        check("bp_resume_1", {24'd0, out_data}, 32'd12);

        // Random traffic, mostly legal sums built from the model's history
        do_reset();
        for (int i = 0; i < 600; i++) begin
            y = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                s = $urandom_range(0, 1023);
            end else begin
                r = $urandom_range(0, 255);
                s = y ? r : (r + 2 * mx1 + mx2);
            end
            step($urandom_range(0, 3) != 0, s, y, $urandom_range(0, 2) != 0, 1'b1);
        end

        // Saturation: illegal sum with sync re-enters ERROR and counts each time
        do_reset();
        for (int i = 0; i < 65540; i++) step(1'b1, 300, 1'b1, 1'b1, 1'b0);
        step(1'b1, 300, 1'b1, 1'b1, 1'b1);
        check("sat_count", {16'd0, err_count}, 32'd65535);

        // Reset wins over a simultaneous input
        step(1'b1, 8, 1'b1, 1'b1, 1'b1);
        do_reset();
        check("rst_count", {16'd0, err_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
